// File: rtl/qdrc_phy_eye_center.sv
// Per-bit read-data deskew trainer: sweeps each bit's IODELAY, finds the widest stable eye, and
// parks the tap at its centre. Define QDRC_EYE_RETRAIN_EN for single-bit retrain. DATA_WIDTH >= 2.
module qdrc_phy_eye_center #(
    parameter int unsigned DATA_WIDTH    = 36,
    parameter int unsigned TAP_BITS      = 5,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLE_CYCLES = 16,
    parameter int unsigned MIN_EYE       = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           train_start,
`ifdef QDRC_EYE_RETRAIN_EN
    input  logic                           retrain_start,
    input  logic [$clog2(DATA_WIDTH)-1:0]  retrain_idx,
`endif
    output logic                           train_busy,
    output logic                           train_done,
    output logic                           train_fail,
    input  logic [DATA_WIDTH-1:0]          q_rise,
    input  logic [DATA_WIDTH-1:0]          q_fall,
    output logic [DATA_WIDTH-1:0]          dly_inc_dec_n,
    output logic [DATA_WIDTH-1:0]          dly_en,
    output logic [DATA_WIDTH-1:0]          dly_rst,
    output logic [DATA_WIDTH-1:0]          aligned,
    output logic [DATA_WIDTH-1:0]          fail_mask,
    output logic [DATA_WIDTH*TAP_BITS-1:0] tap_value,
    output logic [3:0]                     state_prb
);

    localparam int unsigned IDX_W   = $clog2(DATA_WIDTH);
    localparam int unsigned LEN_W   = TAP_BITS + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES
                                                                      : SAMPLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [LEN_W-1:0] MAX_TAP  = LEN_W'((1 << TAP_BITS) - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StRstDly    = 4'd1,
        StSettle    = 4'd2,
        StSample    = 4'd3,
        StEval      = 4'd4,
        StStep      = 4'd5,
        StCenterRst = 4'd6,
        StCenterInc = 4'd7,
        StAlign     = 4'd8,
        StNext      = 4'd9,
        StDone      = 4'd10
    } state_e;

    state_e                  state;
    logic [IDX_W-1:0]        bit_idx;
    logic [LEN_W-1:0]        tap;
    logic [LEN_W-1:0]        target;
    logic [CNT_W-1:0]        cnt;
    logic                    centering;
    logic                    gap;
    logic                    single;

    logic [DATA_WIDTH-1:0]   q_rise_r;
    logic [DATA_WIDTH-1:0]   q_fall_r;
    logic                    s_rise;
    logic                    s_fall;
    logic                    good;

    logic                    win_ok;
    logic                    win_first;
    logic [LEN_W-1:0]        run_len;
    logic [LEN_W-1:0]        run_start;
    logic                    run_val;
    logic [LEN_W-1:0]        best_len;
    logic [LEN_W-1:0]        best_start;
    logic [LEN_W-1:0]        run_len_nx;
    logic [LEN_W-1:0]        run_start_nx;
    logic                    run_val_nx;

    logic [TAP_BITS-1:0]     tap_arr [DATA_WIDTH];

    assign good          = s_rise ^ s_fall;
    assign dly_inc_dec_n = '1;
    assign train_fail    = |fail_mask;
    assign state_prb     = state;

    always_comb begin
        tap_value = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            tap_value[i*TAP_BITS +: TAP_BITS] = tap_arr[i];
        end
    end

    // Run tracker for the tap just sampled; a value flip inside good taps starts a new run.
    always_comb begin
        run_len_nx   = run_len;
        run_start_nx = run_start;
        run_val_nx   = run_val;
        if (!win_ok) begin
            run_len_nx = '0;
        end else if (run_len != '0 && win_first == run_val) begin
            run_len_nx = run_len + 1'b1;
        end else begin
            run_len_nx   = LEN_W'(1);
            run_start_nx = tap;
            run_val_nx   = win_first;
        end
    end

    always_ff @(posedge clk) begin
        q_rise_r <= q_rise;
        q_fall_r <= q_fall;
        s_rise   <= q_rise_r[bit_idx];
        s_fall   <= q_fall_r[bit_idx];

        if (reset) begin
            state      <= StIdle;
            bit_idx    <= '0;
            tap        <= '0;
            target     <= '0;
            cnt        <= '0;
            centering  <= 1'b0;
            gap        <= 1'b0;
            single     <= 1'b0;
            win_ok     <= 1'b0;
            win_first  <= 1'b0;
            run_len    <= '0;
            run_start  <= '0;
            run_val    <= 1'b0;
            best_len   <= '0;
            best_start <= '0;
            train_busy <= 1'b0;
            train_done <= 1'b0;
            dly_en     <= '0;
            dly_rst    <= '1;
            aligned    <= '1;
            fail_mask  <= '0;
            tap_arr    <= '{default: '0};
        end else begin
            dly_en  <= '0;
            dly_rst <= '0;
            unique case (state)
                StIdle: begin
                    if (train_start) begin
                        bit_idx    <= '0;
                        single     <= 1'b0;
                        train_busy <= 1'b1;
                        train_done <= 1'b0;
                        fail_mask  <= '0;
                        run_len    <= '0;
                        best_len   <= '0;
                        state      <= StRstDly;
                    end
`ifdef QDRC_EYE_RETRAIN_EN
                    else if (retrain_start && 32'(retrain_idx) < DATA_WIDTH) begin
                        bit_idx                <= retrain_idx;
                        single                 <= 1'b1;
                        train_busy             <= 1'b1;
                        train_done             <= 1'b0;
                        fail_mask[retrain_idx] <= 1'b0;
                        run_len                <= '0;
                        best_len               <= '0;
                        state                  <= StRstDly;
                    end
`endif
                end
                StRstDly: begin
                    dly_rst[bit_idx] <= 1'b1;
                    tap              <= '0;
                    cnt              <= '0;
                    centering        <= 1'b0;
                    run_len          <= '0;
                    run_start        <= '0;
                    run_val          <= 1'b0;
                    best_len         <= '0;
                    best_start       <= '0;
                    state            <= StSettle;
                end
                StSettle: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= StSample;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StSample: begin
                    if (cnt == '0) begin
                        win_ok    <= good;
                        win_first <= s_rise;
                    end else begin
                        win_ok <= win_ok & good & (s_rise == win_first);
                    end
                    if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= centering ? StAlign : StEval;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StEval: begin
                    run_len   <= run_len_nx;
                    run_start <= run_start_nx;
                    run_val   <= run_val_nx;
                    // Strict compare keeps the earliest of equally wide eyes.
                    if (run_len_nx > best_len) begin
                        best_len   <= run_len_nx;
                        best_start <= run_start_nx;
                    end
                    state <= (tap == MAX_TAP) ? StCenterRst : StStep;
                end
                StStep: begin
                    dly_en[bit_idx] <= 1'b1;
                    tap             <= tap + 1'b1;
                    cnt             <= '0;
                    state           <= StSettle;
                end
                StCenterRst: begin
                    dly_rst[bit_idx] <= 1'b1;
                    tap              <= '0;
                    gap              <= 1'b1;
                    if (best_len < LEN_W'(MIN_EYE)) begin
                        fail_mask[bit_idx] <= 1'b1;
                        target             <= '0;
                    end else begin
                        target <= best_start + ((best_len - 1'b1) >> 1);
                    end
                    state <= StCenterInc;
                end
                StCenterInc: begin
                    if (tap == target) begin
                        centering <= 1'b1;
                        cnt       <= '0;
                        state     <= StSettle;
                    end else if (gap) begin
                        gap <= 1'b0;
                    end else begin
                        dly_en[bit_idx] <= 1'b1;
                        tap             <= tap + 1'b1;
                        gap             <= 1'b1;
                    end
                end
                StAlign: begin
                    aligned[bit_idx] <= win_first;
                    if (!win_ok) begin
                        fail_mask[bit_idx] <= 1'b1;
                    end
                    tap_arr[bit_idx] <= target[TAP_BITS-1:0];
                    state            <= StNext;
                end
                StNext: begin
                    if (!single && bit_idx != LAST_BIT) begin
                        bit_idx <= bit_idx + 1'b1;
                        state   <= StRstDly;
                    end else begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    train_done <= 1'b1;
                    train_busy <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_qdrc_phy_eye_center.sv
// Bench for qdrc_phy_eye_center: IODELAY/eye-pattern model drives q_rise/q_fall; an eye-search
// reference model predicts per-bit tap, alignment and fail results.
module tb_qdrc_phy_eye_center;

    localparam int DW  = 4;
    localparam int TB  = 5;
    localparam int NT  = 32;
    localparam int MIN = 3;
    localparam int LIMIT = 8000;

    logic              clk = 1'b0;
    logic              reset;
    logic              train_start;
    logic              train_busy, train_done, train_fail;
    logic [DW-1:0]     q_rise, q_fall;
    logic [DW-1:0]     dly_inc_dec_n, dly_en, dly_rst, aligned, fail_mask;
    logic [DW*TB-1:0]  tap_value;
    logic [3:0]        state_prb;
`ifdef QDRC_EYE_RETRAIN_EN
    logic              retrain_start;
    logic [1:0]        retrain_idx;
`endif

    always #5 clk = ~clk;

    qdrc_phy_eye_center #(
        .DATA_WIDTH(DW), .TAP_BITS(TB), .SETTLE_CYCLES(16), .SAMPLE_CYCLES(16), .MIN_EYE(MIN)
    ) dut (
        .clk(clk), .reset(reset), .train_start(train_start),
`ifdef QDRC_EYE_RETRAIN_EN
        .retrain_start(retrain_start), .retrain_idx(retrain_idx),
`endif
        .train_busy(train_busy), .train_done(train_done), .train_fail(train_fail),
        .q_rise(q_rise), .q_fall(q_fall), .dly_inc_dec_n(dly_inc_dec_n), .dly_en(dly_en),
        .dly_rst(dly_rst), .aligned(aligned), .fail_mask(fail_mask), .tap_value(tap_value),
        .state_prb(state_prb)
    );

    // kind: 0 bad static (rise==fall), 1 good rise=1, 2 good rise=0, 3 good but toggling (unstable)
    int  kind   [DW][NT];
    bit  badbit [DW][NT];
    int  dtap   [DW];
    bit  phase;
    int  en_count;

    int  exp_tap [DW];
    bit  exp_al  [DW];
    bit  exp_fm  [DW];

    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // IODELAY + eye-pattern model.
    initial begin
        q_rise = '0;
        q_fall = '0;
        phase = 1'b0;
        en_count = 0;
        for (int b = 0; b < DW; b++) dtap[b] = 0;
        forever begin
            @(negedge clk);
            phase = ~phase;
            if (dly_en != '0) en_count++;
            for (int b = 0; b < DW; b++) begin
                if (dly_rst[b] === 1'b1) dtap[b] = 0;
                else if (dly_en[b] === 1'b1 && dly_inc_dec_n[b] === 1'b1) dtap[b] = (dtap[b] + 1) % NT;
                case (kind[b][dtap[b]])
                    1: begin q_rise[b] = 1'b1; q_fall[b] = 1'b0; end
                    2: begin q_rise[b] = 1'b0; q_fall[b] = 1'b1; end
                    3: begin q_rise[b] = phase; q_fall[b] = ~phase; end
                    default: begin q_rise[b] = badbit[b][dtap[b]]; q_fall[b] = badbit[b][dtap[b]]; end
                endcase
            end
        end
    end

    function automatic bit is_good(int b, int t);
        return kind[b][t] == 1 || kind[b][t] == 2;
    endfunction

    function automatic bit rise_at(int b, int t);
        if (kind[b][t] == 1) return 1'b1;
        if (kind[b][t] == 2) return 1'b0;
        return badbit[b][t];
    endfunction

    // Widest run of equal-valued good taps, earliest on a tie; centre rounds down.
    function automatic void model_bit(int b);
        int best_len = 0;
        int best_s = 0;
        for (int s = 0; s < NT; s++) begin
            int len = 0;
            if (is_good(b, s)) begin
                len = 1;
                while (s + len < NT && is_good(b, s + len) && rise_at(b, s + len) == rise_at(b, s))
                    len++;
            end
            if (len > best_len) begin
                best_len = len;
                best_s = s;
            end
        end
        exp_fm[b]  = best_len < MIN;
        exp_tap[b] = exp_fm[b] ? 0 : best_s + (best_len - 1) / 2;
        exp_al[b]  = rise_at(b, exp_tap[b]);
    endfunction

    task automatic clear_bit(int b);
        for (int t = 0; t < NT; t++) begin
            kind[b][t] = (t == 0) ? 0 : (($urandom % 3 == 0) ? 3 : 0);
            badbit[b][t] = 1'($urandom);
        end
    endtask

    task automatic set_eye(int b, int lo, int hi, bit val);
        for (int t = lo; t <= hi && t < NT; t++) kind[b][t] = val ? 1 : 2;
    endtask

    task automatic random_bit(int b);
        int n;
        clear_bit(b);
        n = 1 + $urandom % 2;
        for (int e = 0; e < n; e++) begin
            int lo = $urandom % NT;
            set_eye(b, lo, lo + int'($urandom % 12), 1'($urandom));
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (train_done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, train_done, 1);
    endtask

    task automatic check_results(input string tag);
        logic [DW*TB-1:0] tv;
        logic [DW-1:0]    al, fm;
        for (int b = 0; b < DW; b++) begin
            tv[b*TB +: TB] = TB'(exp_tap[b]);
            al[b] = exp_al[b];
            fm[b] = exp_fm[b];
        end
        check({tag, "_busy_end"}, train_busy, 0);
        check({tag, "_state"}, state_prb, 0);
        check({tag, "_tap"}, tap_value, tv);
        check({tag, "_aligned"}, aligned, al);
        check({tag, "_fail_mask"}, fail_mask, fm);
        check({tag, "_train_fail"}, train_fail, |fm);
    endtask

    task automatic run_train(input string tag);
        for (int b = 0; b < DW; b++) model_bit(b);
        train_start = 1'b1;
        @(negedge clk);
        train_start = 1'b0;
        check({tag, "_busy"}, train_busy, 1);
        check({tag, "_done_clr"}, train_done, 0);
        wait_done(tag);
        check_results(tag);
    endtask

    initial begin
        reset = 1'b1;
        train_start = 1'b0;
`ifdef QDRC_EYE_RETRAIN_EN
        retrain_start = 1'b0;
        retrain_idx = '0;
`endif
        for (int b = 0; b < DW; b++) clear_bit(b);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_dly_rst", dly_rst, 4'hF);
        check("rst_busy", train_busy, 0);
        check("rst_done", train_done, 0);
        check("rst_fail", train_fail, 0);
        check("rst_dly_en", dly_en, 0);
        check("rst_aligned", aligned, 4'hF);
        check("rst_fail_mask", fail_mask, 0);
        check("rst_tap", tap_value, 0);
        check("rst_state", state_prb, 0);
        check("rst_incdec", dly_inc_dec_n, 4'hF);
        @(negedge clk);
        check("rst_dly_rst_low", dly_rst, 0);

        // Clean eye 6..17 on every bit.
        for (int b = 0; b < DW; b++) begin
            clear_bit(b);
            set_eye(b, 6, 17, 1'b1);
        end
        run_train("clean");
        check("clean_tap_const", tap_value, {4{5'd11}});

        // Two equal eyes on bit 0, inverted bit 1, narrow bit 2.
        clear_bit(0); set_eye(0, 2, 6, 1'b1); set_eye(0, 20, 24, 1'b1);
        clear_bit(1); set_eye(1, 8, 19, 1'b0);
        clear_bit(2); set_eye(2, 10, 11, 1'b1);
        run_train("mixed");
        check("mixed_fm_const", fail_mask, 4'b0100);
        check("mixed_tap0_const", tap_value[4:0], 5'd4);
        check("mixed_tap2_const", tap_value[14:10], 5'd0);
        check("mixed_al1_const", aligned[1], 0);

        // Widen second eye on bit 0; others random.
        set_eye(0, 20, 26, 1'b1);
        for (int b = 1; b < DW; b++) random_bit(b);
        run_train("wide");
        check("wide_tap0_const", tap_value[4:0], 5'd23);

        // Reset during bit 1's sweep.
        for (int b = 0; b < DW; b++) random_bit(b);
        train_start = 1'b1;
        @(negedge clk);
        train_start = 1'b0;
        begin
            int n = 0;
            while (dly_rst[1] !== 1'b1 && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            check("abort_reach_bit1", dly_rst[1], 1);
        end
        repeat (300) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        en_count = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        check("abort_dly_rst", dly_rst, 4'hF);
        check("abort_busy", train_busy, 0);
        repeat (40) @(negedge clk);
        check("abort_no_en", en_count, 0);
        check("abort_dly_rst_low", dly_rst, 0);
        check("abort_state", state_prb, 0);
        run_train("after_abort");

        for (int b = 0; b < DW; b++) random_bit(b);
        run_train("rand");

`ifdef QDRC_EYE_RETRAIN_EN
        for (int b = 0; b < DW; b++) begin
            clear_bit(b);
            set_eye(b, 6, 17, 1'b1);
        end
        run_train("pre_retrain");
        clear_bit(3);
        set_eye(3, 14, 24, 1'b1);
        model_bit(3);
        retrain_idx = 2'd3;
        retrain_start = 1'b1;
        @(negedge clk);
        retrain_start = 1'b0;
        check("retrain_busy", train_busy, 1);
        wait_done("retrain");
        check_results("retrain");
        check("retrain_tap_const", tap_value, {5'd19, 5'd11, 5'd11, 5'd11});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qdrc_phy_eye_center.md
Name: qdrc_phy_eye_center

Overview:
- Per-bit read-data deskew trainer for the QDR PHY.
- Trains bits one at a time: resets the bit's IODELAY, sweeps every tap, and records the longest run of stable, valid samples (the eye).
- Returns the tap to the centre of that eye, then records half-word alignment and the final tap per bit.
- Sits between the IDDR capture outputs and the IODELAY control pins; driven by the PHY training sequencer.

Parameters:
- DATA_WIDTH, 36, number of data bits trained.
- TAP_BITS, 5, tap counter width; taps 0..2^TAP_BITS-1 (32 on Virtex6).
- SETTLE_CYCLES, 16, wait cycles after any delay change before sampling.
- SAMPLE_CYCLES, 16, cycles observed per tap.
- MIN_EYE, 3, minimum eye width in taps for a pass.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- train_start  in  1  begin full training; ignored while train_busy=1.
- train_busy  out  1  high from the cycle after train_start until done.
- train_done  out  1  level; set at end, cleared by next accepted train_start or reset.
- train_fail  out  1  OR of fail_mask; valid when train_done=1.
- q_rise  in  DATA_WIDTH  IDDR rising-edge data (training pattern rise=1, fall=0).
- q_fall  in  DATA_WIDTH  IDDR falling-edge data.
- dly_inc_dec_n  out  DATA_WIDTH  all bits constant 1 (increment only).
- dly_en  out  DATA_WIDTH  one-cycle increment pulse, current bit only.
- dly_rst  out  DATA_WIDTH  one-cycle delay reset pulse.
- aligned  out  DATA_WIDTH  1 = bit captured rise=1 at centre tap.
- fail_mask  out  DATA_WIDTH  1 = bit eye narrower than MIN_EYE.
- tap_value  out  DATA_WIDTH*TAP_BITS  final tap per bit; bit i at [i*TAP_BITS +: TAP_BITS].
- state_prb  out  4  current state encoding.

Behaviour:
- Reset values: train_busy=0, train_done=0, train_fail=0, dly_en=0, aligned=all 1, fail_mask=0, tap_value=0, state=IDLE. dly_rst=all 1 for the first cycle after reset deasserts, then 0.
- Reset asserted mid-training aborts immediately; no further dly_en pulses are issued.
- Input path: q_rise/q_fall are registered once across all bits, then the current bit's pair is registered once more. Sampling uses the second stage (2-cycle latency).
- A sample is good when rise^fall=1.
- A tap is good when every sample in the SAMPLE_CYCLES window is good and equal to the first sample of that window. The tap value is the rise bit.
- States:
  - IDLE: on train_start, go to RST_DLY with bit=0; set busy; clear done, fail_mask and the eye trackers.
  - RST_DLY: pulse dly_rst[bit]; tap=0; go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to SAMPLE.
  - SAMPLE: observe SAMPLE_CYCLES, then go to EVAL.
  - EVAL: update eye trackers.
    - Good tap with run_len=0, or value==run_val: run_len+1, first tap of the run stored as run_start.
    - Good tap with a different value: restart run at this tap.
    - Bad tap: run_len=0.
    - If run_len>best_len: copy run to best. Strict comparison, so the earliest eye wins ties.
    - If tap==max tap, go to CENTER_RST. Otherwise go to STEP.
  - STEP: pulse dly_en[bit]; tap+1; go to SETTLE.
  - CENTER_RST: pulse dly_rst[bit].
    - If best_len<MIN_EYE: set fail_mask[bit]; target=0.
    - Otherwise target=best_start+((best_len-1)>>1).
  - CENTER_INC: one dly_en pulse per cycle, separated by 1 idle cycle, until tap==target; then SETTLE (one final sample window), then ALIGN.
  - ALIGN: aligned[bit]=rise sample of that window. If the window is not a good tap, set fail_mask[bit]. Write tap_value[bit]=target. Go to NEXT.
  - NEXT: if bit<DATA_WIDTH-1, bit+1 and go to RST_DLY. Otherwise go to DONE.
  - DONE: set train_done; clear busy; go to IDLE.
- Tap counter is TAP_BITS+1 wide, so the max-tap compare never wraps.
- Trackers are cleared per bit.
- Eye at tap 0 or at max tap is accepted unchanged (no wrap-around search).

Optional Feature:
- Macro: QDRC_EYE_RETRAIN_EN.
- When defined, adds two inputs:
  - retrain_start (1 bit).
  - retrain_idx ($clog2(DATA_WIDTH) bits).
- retrain_start in IDLE trains only bit retrain_idx, then goes to DONE. Only that bit's aligned, fail_mask and tap_value are updated; other bits are untouched.
- retrain_idx>=DATA_WIDTH is ignored.
- If retrain_start and train_start are high together, train_start wins.
- Without the macro, these ports do not exist and behaviour is full training only.

Test Plan:
- Clean bit, DATA_WIDTH=4, eye on taps 6..17 for all bits, rise=1 → tap_value=11 each; aligned=4'hF; fail_mask=0; train_fail=0.
- Bit 2 valid only on taps 10..11 (MIN_EYE=3) → fail_mask=4'b0100; tap_value[2]=0; train_fail=1; the other bits pass.
- Two eyes on bit 0: taps 2..6 and taps 20..24 (equal length) → earliest wins, tap_value[0]=4. Widen the second eye to 20..26 → tap_value[0]=23.
- Bit 1 with rise=0, fall=1 at centre → aligned[1]=0; fail_mask[1]=0.
- Assert reset during bit 1's sweep → no dly_en afterwards; dly_rst all 1 for one cycle; train_start then retrains from bit 0 and produces the correct results.
- With QDRC_EYE_RETRAIN_EN: after a full train, shift bit 3's eye to taps 14..24 and pulse retrain_idx=3 → only tap_value[3] changes, to 19.
